// File: rtl/sequential_divider_8bit.sv
// -----------------------------------------------------------------------------
// sequential_divider_8bit
// Unsigned WIDTH-by-WIDTH restoring divider, one quotient bit per clock.
// The dividend is loaded into B with ClearA_LoadB, and the divisor is taken
// from S when Run starts a division. When the division finishes, B holds the
// quotient and A holds the remainder.
//
// Ports:
//   Clk           in   system clock
//   Reset         in   synchronous, active-low reset
//   Run           in   active-low button; starts a division from IDLE
//   ClearA_LoadB  in   active-low button; clears A and loads S into B (IDLE only)
//   S             in   [WIDTH-1:0] switches: dividend on load, divisor on Run
//   Aval          out  [WIDTH-1:0] register A (partial remainder / remainder)
//   Bval          out  [WIDTH-1:0] register B (dividend / quotient)
//   Busy          out  high while iterations are in progress
//   Done          out  sticky; set when a division completes
//   DivZero       out  sticky; set when the divisor latched at start was zero
// -----------------------------------------------------------------------------
module sequential_divider_8bit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;

  // Shifted partial remainder. It needs WIDTH+1 bits because A can be as
  // large as 2^WIDTH-2, so 2A+1 does not fit in WIDTH bits.
  logic [WIDTH:0]   p_s;
  logic             ge_s;
  logic [WIDTH-1:0] a_sub_s;

  // Datapath for one restoring-division step.
  always_comb begin
    p_s     = {a_q, b_q[WIDTH-1]};
    ge_s    = (p_s >= {1'b0, d_q});
    // Only the low WIDTH bits of the difference are kept. When ge_s is set
    // the true difference is below D, so the truncation loses nothing.
    a_sub_s = p_s[WIDTH-1:0] - d_q;
  end

  // Next-state and next-register values for the control FSM.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    divzero_d = divzero_q;

    case (state_q)
      ST_IDLE: begin
        // Load takes priority over Run on the same edge.
        if (!ClearA_LoadB) begin
          a_d       = {WIDTH{1'b0}};
          b_d       = S;
          done_d    = 1'b0;
          divzero_d = 1'b0;
        end else if (!Run) begin
          // B is kept, so a repeated Run divides the previous quotient.
          d_d       = S;
          a_d       = {WIDTH{1'b0}};
          divzero_d = (S == {WIDTH{1'b0}});
          done_d    = 1'b0;
          cnt_d     = {CNT_W{1'b0}};
          busy_d    = 1'b1;
          state_d   = ST_DIV;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DIV: begin
        // A zero divisor needs no special case: every step subtracts zero,
        // which gives an all-ones quotient and the dividend as remainder.
        if (ge_s) begin
          a_d = a_sub_s;
        end else begin
          a_d = p_s[WIDTH-1:0];
        end
        b_d   = {b_q[WIDTH-2:0], ge_s};
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_DIV;
        end
      end

      ST_HOLD: begin
        // Wait for Run to be released, so a long press runs only one division.
        if (Run) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      d_q       <= {WIDTH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign Aval    = a_q;
  assign Bval    = b_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;

endmodule
